reaction_game_ctrl: RTL and testbench

Top-level sequencer for the reaction-time game. It arms a round on the player's go button and waits a pseudo-random delay, then lights the go lamp and enables the 3-digit BCD millisecond counter. It captures the count when the stop button is pressed and keeps the best (lowest) time. It also flags false starts and timeouts. It sits between the debounced/synchronized pushbuttons and the BCD counter, and owns the counter's clear and enable lines.

---
 rtl/reaction_game_ctrl_pkg.sv | 28 ++
 rtl/reaction_game_ctrl_lfsr16.sv | 30 +++
 rtl/reaction_game_ctrl.sv | 163 ++++++++++++++++
 tb/tb_reaction_game_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_game_ctrl_pkg.sv
// Shared definitions for the reaction-time game controller.
// Holds the state encoding, the BCD saturation value, the LFSR feedback taps
// and the single-step LFSR helper used by the random-delay generator.
package reaction_game_ctrl_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_RAND = 3'd1;
    localparam logic [2:0] TIMING    = 3'd2;
    localparam logic [2:0] DONE      = 3'd3;
    localparam logic [2:0] FOUL      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = IDLE,
        S_WAIT_RAND = WAIT_RAND,
        S_TIMING    = TIMING,
        S_DONE      = DONE,
        S_FOUL      = FOUL
    } state_e;

    localparam logic [11:0] BCD_MAX   = 12'h999;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shifting Galois step: the bit shifted out folds back onto the taps.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/reaction_game_ctrl_lfsr16.sv
// 16-bit Galois LFSR, advancing on every clock; source of the random delay.
// Ports:
//   clk_i    system clock
//   ar_i     synchronous active-high reset, loads SEED
//   state_o  current 16-bit LFSR state
module lfsr16
    import reaction_game_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        ar_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d  = lfsr_step(lfsr_q);
    assign state_o = lfsr_q;

    always_ff @(posedge clk_i) begin
        if (ar_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer.
// A go press arms a round and waits a pseudo-random number of milliseconds,
// then lights the go lamp and lets the external BCD counter run off the
// millisecond tick. A stop press captures the count and tracks the best time.
// Stopping before the lamp is a false start; a counter overflow ends the round
// with 999.
// Ports:
//   clk_i           system clock
//   ar_i            synchronous active-high reset
//   btn_go_i        go button level (synchronized)
//   btn_stop_i      stop button level (synchronized)
//   cnt_bcd_i       counter value {hundreds, tens, ones}
//   cnt_ovf_i       counter sitting at 999
//   ctr_clr_o       counter clear, held while waiting for the lamp
//   ctr_en_o        counter increment pulse, one per ms while timing
//   go_lamp_o       lamp, high while timing
//   result_bcd_o    last captured time
//   best_bcd_o      best valid time since reset
//   result_valid_o  high in DONE
//   false_start_o   high in FOUL
//   new_best_o      one-cycle pulse when best_bcd_o changes
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | after reset, waiting for the first go press
// WAIT_RAND | random pre-lamp delay running, counter held clear
// TIMING    | lamp lit, counter running
// DONE      | result captured, waiting for next go press
// FOUL      | stop pressed before the lamp, waiting for go
module reaction_game_ctrl
    import reaction_game_ctrl_pkg::*;
#(
    parameter int          TICK_DIV     = 10000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        ar_i,
    input  logic        btn_go_i,
    input  logic        btn_stop_i,
    input  logic [11:0] cnt_bcd_i,
    input  logic        cnt_ovf_i,
    output logic        ctr_clr_o,
    output logic        ctr_en_o,
    output logic        go_lamp_o,
    output logic [11:0] result_bcd_o,
    output logic [11:0] best_bcd_o,
    output logic        result_valid_o,
    output logic        false_start_o,
    output logic        new_best_o
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));

    state_e             state_q, state_d;
    logic               go_prev_q, stop_prev_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic [11:0]        result_q, result_d;
    logic [11:0]        best_q, best_d;
    logic               new_best_q, new_best_d;

    logic [15:0]        lfsr_state;
    logic [DLY_W-1:0]   delay_load;
    logic               go_rise, stop_rise, ms_tick;
    logic               unused_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .ar_i    (ar_i),
        .state_o (lfsr_state)
    );

    assign unused_lfsr = ^lfsr_state[15:RAND_BITS];

    assign go_rise    = btn_go_i & ~go_prev_q;
    assign stop_rise  = btn_stop_i & ~stop_prev_q;
    assign ms_tick    = (div_q == DIV_W'(TICK_DIV - 1));
    assign delay_load = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_state[RAND_BITS-1:0]);

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        result_d   = result_q;
        best_d     = best_q;
        new_best_d = 1'b0;
        div_d      = ms_tick ? '0 : div_q + 1'b1;

        case (state_q)
            S_IDLE, S_DONE, S_FOUL: begin
                if (go_rise) begin
                    state_d = S_WAIT_RAND;
                    delay_d = delay_load;
                    div_d   = '0;
                end
            end
            S_WAIT_RAND: begin
                // A stop press beats expiry landing in the same cycle.
                if (stop_rise) begin
                    state_d = S_FOUL;
                end else if ((delay_q == '0) || (ms_tick && (delay_q == DLY_W'(1)))) begin
                    state_d = S_TIMING;
                    div_d   = '0;
                end else if (ms_tick) begin
                    delay_d = delay_q - 1'b1;
                end
            end
            S_TIMING: begin
                if (stop_rise) begin
                    state_d  = S_DONE;
                    result_d = cnt_bcd_i;
                    // Packed BCD orders the same as its decimal value.
                    if (cnt_bcd_i < best_q) begin
                        best_d     = cnt_bcd_i;
                        new_best_d = 1'b1;
                    end
                end else if (cnt_ovf_i) begin
                    state_d  = S_DONE;
                    result_d = BCD_MAX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (ar_i) begin
            state_q     <= S_IDLE;
            go_prev_q   <= 1'b1;
            stop_prev_q <= 1'b1;
            div_q       <= '0;
            delay_q     <= '0;
            result_q    <= 12'h000;
            best_q      <= BCD_MAX;
            new_best_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            go_prev_q   <= btn_go_i;
            stop_prev_q <= btn_stop_i;
            div_q       <= div_d;
            delay_q     <= delay_d;
            result_q    <= result_d;
            best_q      <= best_d;
            new_best_q  <= new_best_d;
        end
    end

    assign ctr_clr_o      = (state_q == S_WAIT_RAND);
    assign go_lamp_o      = (state_q == S_TIMING);
    assign ctr_en_o       = go_lamp_o & ms_tick;
    assign result_valid_o = (state_q == S_DONE);
    assign false_start_o  = (state_q == S_FOUL);
    assign result_bcd_o   = result_q;
    assign best_bcd_o     = best_q;
    assign new_best_o     = new_best_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
module tb_reaction_game_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        ar = 1'b1;
    logic        btn_go = 1'b0;
    logic        btn_stop = 1'b0;
    logic [11:0] cnt_bcd;
    logic        cnt_ovf;
    logic        ctr_clr, ctr_en, go_lamp, result_valid, false_start, new_best;
    logic [11:0] result_bcd, best_bcd;

    logic [11:0] model_cnt = 12'h000;
    logic        ovr_en = 1'b0;
    logic [11:0] ovr_val = 12'h000;
    logic        ovf_force = 1'b0;
    logic [15:0] ref_lfsr = 16'h0000;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        go;
        logic        stop;
        logic        exp_clr;
        logic        exp_lamp;
        logic        exp_valid;
        logic        exp_foul;
        logic [11:0] exp_best;
    } vec_t;

    vec_t vecs[11];

    reaction_game_ctrl #(
        .TICK_DIV     (TD),
        .MIN_DELAY_MS (2),
        .RAND_BITS    (2),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk_i          (clk),
        .ar_i           (ar),
        .btn_go_i       (btn_go),
        .btn_stop_i     (btn_stop),
        .cnt_bcd_i      (cnt_bcd),
        .cnt_ovf_i      (cnt_ovf),
        .ctr_clr_o      (ctr_clr),
        .ctr_en_o       (ctr_en),
        .go_lamp_o      (go_lamp),
        .result_bcd_o   (result_bcd),
        .best_bcd_o     (best_bcd),
        .result_valid_o (result_valid),
        .false_start_o  (false_start),
        .new_best_o     (new_best)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] h, t, o;
        h = v[11:8];
        t = v[7:4];
        o = v[3:0];
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            o = o + 4'd1;
        end
        return {h, t, o};
    endfunction

    // Counter behaviour as seen from the controller side.
    always @(posedge clk) begin
        if (ctr_clr) model_cnt <= 12'h000;
        else if (ctr_en && model_cnt != 12'h999) model_cnt <= bcd_inc(model_cnt);
    end

    assign cnt_bcd = ovr_en ? ovr_val : model_cnt;
    assign cnt_ovf = ovf_force | (cnt_bcd == 12'h999);

    always @(posedge clk) begin
        if (ar) ref_lfsr <= 16'hACE1;
        else if (ref_lfsr[0]) ref_lfsr <= (ref_lfsr >> 1) ^ 16'hB400;
        else ref_lfsr <= ref_lfsr >> 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Press go, then count cycles from WAIT_RAND entry to lamp onset.
    task automatic start_round(input string tag);
        int exp_cyc;
        int n;
        btn_go = 1'b1;
        exp_cyc = (2 + int'(ref_lfsr[1:0])) * TD;
        step();
        btn_go = 1'b0;
        chk1({tag, "_wait_clr"}, ctr_clr, 1'b1);
        n = 0;
        while (!go_lamp && n < 200) begin
            step();
            n++;
        end
        chk12({tag, "_lamp_onset"}, 12'(n), 12'(exp_cyc));
        chk1({tag, "_lamp_on"}, go_lamp, 1'b1);
    endtask

    task automatic wait_count(input string tag, input logic [11:0] target);
        int n;
        n = 0;
        while (cnt_bcd != target && n < 400) begin
            step();
            n++;
        end
        chk12({tag, "_reach_cnt"}, cnt_bcd, target);
    endtask

    initial begin
        //            go    stop  clr   lamp  valid foul  best
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h999};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h999};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h999};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h999};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h999};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h999};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h999};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h999};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h999};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h999};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h999};

        // Reset with go held high.
        ar = 1'b1;
        btn_go = 1'b1;
        step();
        step();
        chk1("rst_clr", ctr_clr, 1'b0);
        chk1("rst_en", ctr_en, 1'b0);
        chk1("rst_lamp", go_lamp, 1'b0);
        chk1("rst_valid", result_valid, 1'b0);
        chk1("rst_foul", false_start, 1'b0);
        chk1("rst_newbest", new_best, 1'b0);
        chk12("rst_result", result_bcd, 12'h000);
        chk12("rst_best", best_bcd, 12'h999);
        ar = 1'b0;

        for (int i = 0; i < 11; i++) begin
            btn_go = vecs[i].go;
            btn_stop = vecs[i].stop;
            step();
            chk1($sformatf("vec%0d_clr", i), ctr_clr, vecs[i].exp_clr);
            chk1($sformatf("vec%0d_lamp", i), go_lamp, vecs[i].exp_lamp);
            chk1($sformatf("vec%0d_valid", i), result_valid, vecs[i].exp_valid);
            chk1($sformatf("vec%0d_foul", i), false_start, vecs[i].exp_foul);
            chk12($sformatf("vec%0d_best", i), best_bcd, vecs[i].exp_best);
        end
        btn_go = 1'b0;
        btn_stop = 1'b0;
        step();

        // Round 1: first tick in TIMING, stop at 005.
        start_round("r1");
        chk1("r1_en_entry", ctr_en, 1'b0);
        step();
        step();
        step();
        chk1("r1_first_tick", ctr_en, 1'b1);
        wait_count("r1", 12'h005);
        btn_stop = 1'b1;
        step();
        chk1("r1_valid", result_valid, 1'b1);
        chk1("r1_lamp_off", go_lamp, 1'b0);
        chk1("r1_en_off", ctr_en, 1'b0);
        chk12("r1_result", result_bcd, 12'h005);
        chk12("r1_best", best_bcd, 12'h005);
        chk1("r1_newbest", new_best, 1'b1);
        btn_stop = 1'b0;
        step();
        chk1("r1_newbest_pulse", new_best, 1'b0);
        chk1("r1_valid_hold", result_valid, 1'b1);

        // Round 2: slower time, best stays.
        start_round("r2");
        wait_count("r2", 12'h012);
        btn_stop = 1'b1;
        step();
        chk12("r2_result", result_bcd, 12'h012);
        chk12("r2_best", best_bcd, 12'h005);
        chk1("r2_newbest", new_best, 1'b0);
        btn_stop = 1'b0;
        step();

        // Round 3: overflow ends the round with 999.
        start_round("r3");
        step();
        ovf_force = 1'b1;
        step();
        ovf_force = 1'b0;
        chk1("r3_valid", result_valid, 1'b1);
        chk12("r3_result", result_bcd, 12'h999);
        chk12("r3_best", best_bcd, 12'h005);
        chk1("r3_newbest", new_best, 1'b0);
        step();

        // Round 4: stop and overflow together, stop path wins.
        start_round("r4");
        ovr_en = 1'b1;
        ovr_val = 12'h003;
        ovf_force = 1'b1;
        btn_stop = 1'b1;
        step();
        ovr_en = 1'b0;
        ovf_force = 1'b0;
        btn_stop = 1'b0;
        chk12("r4_result", result_bcd, 12'h003);
        chk12("r4_best", best_bcd, 12'h003);
        chk1("r4_newbest", new_best, 1'b1);
        btn_stop = 1'b1;
        step();
        btn_stop = 1'b0;
        chk1("r4_stop_ignored", result_valid, 1'b1);
        chk12("r4_result_hold", result_bcd, 12'h003);

        // Round 5: reset during TIMING.
        start_round("r5");
        step();
        step();
        ar = 1'b1;
        step();
        chk1("r5_lamp", go_lamp, 1'b0);
        chk1("r5_clr", ctr_clr, 1'b0);
        chk1("r5_valid", result_valid, 1'b0);
        chk12("r5_best", best_bcd, 12'h999);
        chk12("r5_result", result_bcd, 12'h000);
        ar = 1'b0;
        step();
        chk1("r5_idle_lamp", go_lamp, 1'b0);
        chk1("r5_idle_clr", ctr_clr, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
